// File: rtl/hilo_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : hilo_div_unit
// Purpose  : Iterative HI/LO divide unit. Owns the architectural HI/LO
//            registers and services divu, mfhi, mflo, mthi and mtlo.
//            Restoring division retires one quotient bit per cycle.
//            Define DIV_SIGNED_EN to add signed div (funct 26) with a
//            one-cycle sign fix-up state.
// Revision : 1.0 - initial release
// ============================================================================
module hilo_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_valid,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             flush,
    output logic [WIDTH-1:0] hilo_rdata,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam logic [5:0] FUNCT_DIVU = 6'd27;
    localparam logic [5:0] FUNCT_MFHI = 6'd16;
    localparam logic [5:0] FUNCT_MTHI = 6'd17;
    localparam logic [5:0] FUNCT_MFLO = 6'd18;
    localparam logic [5:0] FUNCT_MTLO = 6'd19;
`ifdef DIV_SIGNED_EN
    localparam logic [5:0] FUNCT_DIV  = 6'd26;
`endif

    typedef enum logic [1:0] {
`ifdef DIV_SIGNED_EN
        ST_FIX  = 2'd2,
`endif
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   dvd_q, dvd_d;   // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0]   dsr_q, dsr_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               dbz_q, dbz_d;
`ifdef DIV_SIGNED_EN
    logic               sgn_q, sgn_d;   // current divide is signed
    logic               negq_q, negq_d; // quotient must be negated
    logic               negr_q, negr_d; // remainder must be negated
`endif

    logic               is_divu, is_div, is_mfhi, is_mflo, is_mthi, is_mtlo;
    logic               is_start, hilo_op, in_fix;
    logic [WIDTH:0]     rem_ext;
    logic               rem_ge;
    logic [WIDTH-1:0]   rem_next, quo_next;

    // Instruction decode, stall and HI/LO read port
    always_comb begin
        is_divu = op_valid && (funct == FUNCT_DIVU);
        is_mfhi = op_valid && (funct == FUNCT_MFHI);
        is_mflo = op_valid && (funct == FUNCT_MFLO);
        is_mthi = op_valid && (funct == FUNCT_MTHI);
        is_mtlo = op_valid && (funct == FUNCT_MTLO);
`ifdef DIV_SIGNED_EN
        is_div  = op_valid && (funct == FUNCT_DIV);
        in_fix  = (state_q == ST_FIX);
`else
        is_div  = 1'b0;
        in_fix  = 1'b0;
`endif
        is_start   = is_divu || is_div;
        hilo_op    = is_start || is_mfhi || is_mflo || is_mthi || is_mtlo;
        stall      = hilo_op && (busy_q || in_fix);
        hilo_rdata = is_mfhi ? hi_q : (is_mflo ? lo_q : '0);
    end

    // One restoring-division step; the partial remainder is widened by one bit
    // so the compare never wraps. When the compare succeeds the true difference
    // is below the divisor, so a WIDTH-bit subtraction is exact.
    always_comb begin
        rem_ext  = {rem_q, dvd_q[WIDTH-1]};
        rem_ge   = (rem_ext >= {1'b0, dsr_q});
        rem_next = rem_ge ? (rem_ext[WIDTH-1:0] - dsr_q) : rem_ext[WIDTH-1:0];
        quo_next = {dvd_q[WIDTH-2:0], rem_ge};
    end

    // Next-state: accept, iterate, optional sign fix-up, HI/LO moves
    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dbz_d   = dbz_q;
`ifdef DIV_SIGNED_EN
        sgn_d   = sgn_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (is_start && !flush) begin
                    state_d = ST_RUN;
                    busy_d  = 1'b1;
                    cnt_d   = CNT_W'(WIDTH - 1);
                    rem_d   = '0;
                    dvd_d   = rs_data;
                    dsr_d   = rt_data;
                    dbz_d   = 1'b0;
`ifdef DIV_SIGNED_EN
                    sgn_d   = is_div;
                    negq_d  = is_div && (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
                    negr_d  = is_div && rs_data[WIDTH-1];
                    if (is_div && rs_data[WIDTH-1]) dvd_d = -rs_data;
                    if (is_div && rt_data[WIDTH-1]) dsr_d = -rt_data;
`endif
                end else begin
                    if (is_mthi) hi_d = rs_data;
                    if (is_mtlo) lo_d = rs_data;
                end
            end
            ST_RUN: begin
                if (flush) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    dvd_d = quo_next;
                    rem_d = rem_next;
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else begin
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
`ifdef DIV_SIGNED_EN
                        if (sgn_q) state_d = ST_FIX;
                        else begin
`else
                        begin
`endif
                            lo_d   = quo_next;
                            hi_d   = rem_next;
                            done_d = 1'b1;
                            dbz_d  = (dsr_q == '0);
                        end
                    end
                end
            end
`ifdef DIV_SIGNED_EN
            // Magnitude result sits in dvd/rem; apply signs unless divisor was 0
            ST_FIX: begin
                state_d = ST_IDLE;
                if (!flush) begin
                    lo_d   = (negq_q && (dsr_q != '0)) ? -dvd_q : dvd_q;
                    hi_d   = (negr_q && (dsr_q != '0)) ? -rem_q : rem_q;
                    done_d = 1'b1;
                    dbz_d  = (dsr_q == '0);
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and architectural registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
`ifdef DIV_SIGNED_EN
            sgn_q   <= 1'b0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
`ifdef DIV_SIGNED_EN
            sgn_q   <= sgn_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
`endif
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_hilo_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_hilo_div_unit
// Purpose  : Directed self-checking bench for hilo_div_unit (WIDTH=32).
// Revision : 1.0 - initial release
// ============================================================================
module tb_hilo_div_unit;

    localparam logic [5:0] F_DIVU = 6'd27;
    localparam logic [5:0] F_DIV  = 6'd26;
    localparam logic [5:0] F_MFHI = 6'd16;
    localparam logic [5:0] F_MFLO = 6'd18;
    localparam logic [5:0] F_MTHI = 6'd17;
    localparam logic [5:0] F_MTLO = 6'd19;
    localparam logic [5:0] F_ADD  = 6'd32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        op_valid;
    logic [5:0]  funct;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        flush;
    logic [31:0] hilo_rdata;
    logic        stall;
    logic        busy;
    logic        done;
    logic        div_by_zero;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    hilo_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .op_valid    (op_valid),
        .funct       (funct),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .flush       (flush),
        .hilo_rdata  (hilo_rdata),
        .stall       (stall),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    // advance to 1 ns after the next rising edge
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        op_valid = v;
        funct    = f;
        rs_data  = a;
        rt_data  = b;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        flush = 1'b0;
        drive(1'b0, 6'd0, 32'd0, 32'd0);
        #17;
        n_tests++;
        if ({busy, done, div_by_zero} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags: got %b want 000", {busy, done, div_by_zero});
        end
        rst_n = 1'b1;
        tick;
        drive(1'b1, F_MFHI, 32'd0, 32'd0); #1;
        n_tests++;
        if (hilo_rdata !== 32'd0 || stall !== 1'b0) begin
            n_fail++; $display("FAIL reset_hi: got %h stall %b want 0 stall 0", hilo_rdata, stall);
        end
        tick;
        drive(1'b1, F_MFLO, 32'd0, 32'd0); #1;
        n_tests++;
        if (hilo_rdata !== 32'd0) begin
            n_fail++; $display("FAIL reset_lo: got %h want 0", hilo_rdata);
        end
        tick;
        drive(1'b0, 6'd0, 32'd0, 32'd0);
    endtask

    // divide a/b, check busy window and done cycle, then read LO and HI
    task automatic test_divu(input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] exp_lo, input logic [31:0] exp_hi, input logic exp_dbz);
        tick;
        drive(1'b1, F_DIVU, a, b); #1;
        n_tests++;
        if (busy !== 1'b0 || stall !== 1'b0) begin
            n_fail++; $display("FAIL divu_accept_cycle: busy %b stall %b want 0 0", busy, stall);
        end
        tick;
        drive(1'b0, 6'd0, 32'd0, 32'd0);
        for (int c = 1; c <= 32; c++) begin
            #1;
            n_tests++;
            if ({busy, done} !== 2'b10) begin
                n_fail++; $display("FAIL divu_busy_T+%0d: busy,done %b want 10", c, {busy, done});
            end
            tick;
        end
        drive(1'b1, F_MFLO, 32'd0, 32'd0); #1;
        n_tests++;
        if ({busy, done, div_by_zero} !== {2'b01, exp_dbz}) begin
            n_fail++; $display("FAIL divu_done: busy,done,dbz %b want 01%b", {busy, done, div_by_zero}, exp_dbz);
        end
        n_tests++;
        if (hilo_rdata !== exp_lo) begin
            n_fail++; $display("FAIL divu_lo: got %h want %h", hilo_rdata, exp_lo);
        end
        tick;
        drive(1'b1, F_MFHI, 32'd0, 32'd0); #1;
        n_tests++;
        if (hilo_rdata !== exp_hi || done !== 1'b0 || div_by_zero !== exp_dbz) begin
            n_fail++; $display("FAIL divu_hi: got %h done %b dbz %b want %h 0 %b", hilo_rdata, done, div_by_zero, exp_hi, exp_dbz);
        end
        tick;
        drive(1'b0, 6'd0, 32'd0, 32'd0);
    endtask

    task automatic test_stall;
        tick;
        drive(1'b1, F_DIVU, 32'd1000, 32'd10);                    // T
        tick;
        drive(1'b0, 6'd0, 32'd0, 32'd0); #1;                      // T+1
        n_tests++;
        if (div_by_zero !== 1'b0) begin
            n_fail++; $display("FAIL dbz_clear_on_accept: got %b want 0", div_by_zero);
        end
        tick;                                                     // T+2
        tick;                                                     // T+3
        drive(1'b1, F_ADD, 32'd1, 32'd2); #1;
        n_tests++;
        if (stall !== 1'b0) begin
            n_fail++; $display("FAIL stall_unrelated: got %b want 0", stall);
        end
        tick;                                                     // T+4
        drive(1'b0, 6'd0, 32'd0, 32'd0);
        for (int c = 5; c <= 32; c++) begin
            tick;
            drive(1'b1, F_MFLO, 32'd0, 32'd0); #1;
            n_tests++;
            if ({stall, busy} !== 2'b11) begin
                n_fail++; $display("FAIL stall_mflo_T+%0d: stall,busy %b want 11", c, {stall, busy});
            end
        end
        tick; #1;                                                 // T+33
        n_tests++;
        if ({stall, done} !== 2'b01 || hilo_rdata !== 32'd100) begin
            n_fail++; $display("FAIL stall_release: stall,done %b data %h want 01 00000064", {stall, done}, hilo_rdata);
        end
        tick;
        drive(1'b0, 6'd0, 32'd0, 32'd0);
    endtask

    task automatic test_back_to_back;
        tick;
        drive(1'b1, F_DIVU, 32'hFFFF_FFFF, 32'h10);               // T
        tick;
        drive(1'b1, F_DIVU, 32'd200, 32'd13); #1;                 // T+1
        n_tests++;
        if (stall !== 1'b1) begin
            n_fail++; $display("FAIL b2b_stall: got %b want 1", stall);
        end
        for (int c = 2; c <= 32; c++) begin
            tick; #1;
            n_tests++;
            if ({stall, busy, done} !== 3'b110) begin
                n_fail++; $display("FAIL b2b_hold_T+%0d: stall,busy,done %b want 110", c, {stall, busy, done});
            end
        end
        tick; #1;                                                 // T+33
        n_tests++;
        if ({stall, busy, done} !== 3'b001) begin
            n_fail++; $display("FAIL b2b_first_done: stall,busy,done %b want 001", {stall, busy, done});
        end
        tick;                                                     // T+34
        drive(1'b0, 6'd0, 32'd0, 32'd0); #1;
        n_tests++;
        if ({busy, done} !== 2'b10) begin
            n_fail++; $display("FAIL b2b_second_start: busy,done %b want 10", {busy, done});
        end
        for (int c = 35; c <= 66; c++) tick;                      // T+66
        drive(1'b1, F_MFLO, 32'd0, 32'd0); #1;
        n_tests++;
        if (done !== 1'b1 || hilo_rdata !== 32'd15) begin
            n_fail++; $display("FAIL b2b_lo: done %b data %h want 1 0000000f", done, hilo_rdata);
        end
        tick;
        drive(1'b1, F_MFHI, 32'd0, 32'd0); #1;
        n_tests++;
        if (hilo_rdata !== 32'd5) begin
            n_fail++; $display("FAIL b2b_hi: got %h want 00000005", hilo_rdata);
        end
        tick;
        drive(1'b0, 6'd0, 32'd0, 32'd0);
    endtask

    task automatic test_flush;
        int done_seen;
        tick;
        drive(1'b1, F_MTHI, 32'hA5, 32'd0);
        tick;
        drive(1'b1, F_MTLO, 32'h5A, 32'd0);
        tick;
        drive(1'b1, F_DIVU, 32'd50, 32'd3);                       // T
        tick;
        drive(1'b0, 6'd0, 32'd0, 32'd0);                          // T+1
        for (int c = 2; c <= 10; c++) tick;                       // T+10
        flush = 1'b1; #1;
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL flush_pre_busy: got %b want 1", busy);
        end
        tick;                                                     // T+11
        flush = 1'b0; #1;
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL flush_busy_clear: got %b want 0", busy);
        end
        done_seen = 0;
        for (int c = 0; c < 30; c++) begin
            if (done === 1'b1) done_seen++;
            tick;
        end
        n_tests++;
        if (done_seen !== 0) begin
            n_fail++; $display("FAIL flush_no_done: got %0d done pulses want 0", done_seen);
        end
        drive(1'b1, F_MFHI, 32'd0, 32'd0); #1;
        n_tests++;
        if (hilo_rdata !== 32'hA5) begin
            n_fail++; $display("FAIL flush_hi_kept: got %h want 000000a5", hilo_rdata);
        end
        tick;
        drive(1'b1, F_MFLO, 32'd0, 32'd0); #1;
        n_tests++;
        if (hilo_rdata !== 32'h5A) begin
            n_fail++; $display("FAIL flush_lo_kept: got %h want 0000005a", hilo_rdata);
        end
        tick;
        drive(1'b1, F_DIVU, 32'd9, 32'd2);
        flush = 1'b1;
        tick;
        drive(1'b0, 6'd0, 32'd0, 32'd0);
        flush = 1'b0; #1;
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL flush_idle_reject: busy %b want 0", busy);
        end
    endtask

    task automatic test_async_reset;
        tick;
        drive(1'b1, F_DIVU, 32'd1000, 32'd3);                     // T
        tick;
        drive(1'b0, 6'd0, 32'd0, 32'd0);                          // T+1
        for (int c = 2; c <= 20; c++) tick;                       // T+20
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL rst_pre_busy: got %b want 1", busy);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({busy, done, div_by_zero} !== 3'b000) begin
            n_fail++; $display("FAIL rst_async_flags: got %b want 000", {busy, done, div_by_zero});
        end
        drive(1'b1, F_MFHI, 32'd0, 32'd0); #1;
        n_tests++;
        if (hilo_rdata !== 32'd0) begin
            n_fail++; $display("FAIL rst_async_hi: got %h want 0", hilo_rdata);
        end
        #3 rst_n = 1'b1;
        tick; #1;
        n_tests++;
        if (hilo_rdata !== 32'd0 || stall !== 1'b0) begin
            n_fail++; $display("FAIL rst_release_hi: got %h stall %b want 0 0", hilo_rdata, stall);
        end
        tick;
        drive(1'b1, F_MFLO, 32'd0, 32'd0); #1;
        n_tests++;
        if (hilo_rdata !== 32'd0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL rst_release_lo: got %h busy %b want 0 0", hilo_rdata, busy);
        end
        tick;
        drive(1'b0, 6'd0, 32'd0, 32'd0);
    endtask

    task automatic test_signed;
`ifdef DIV_SIGNED_EN
        tick;
        drive(1'b1, F_DIV, 32'hFFFF_FFF9, 32'd2);                 // T: -7 / 2
        tick;
        drive(1'b0, 6'd0, 32'd0, 32'd0); #1;                      // T+1
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL div_busy: got %b want 1", busy);
        end
        for (int c = 2; c <= 33; c++) tick;                       // T+33 (fix-up)
        drive(1'b1, F_MFLO, 32'd0, 32'd0); #1;
        n_tests++;
        if ({stall, done} !== 2'b10) begin
            n_fail++; $display("FAIL div_fix_cycle: stall,done %b want 10", {stall, done});
        end
        tick; #1;                                                 // T+34
        n_tests++;
        if (done !== 1'b1 || hilo_rdata !== 32'hFFFF_FFFD) begin
            n_fail++; $display("FAIL div_lo: done %b data %h want 1 fffffffd", done, hilo_rdata);
        end
        tick;
        drive(1'b1, F_MFHI, 32'd0, 32'd0); #1;
        n_tests++;
        if (hilo_rdata !== 32'hFFFF_FFFF) begin
            n_fail++; $display("FAIL div_hi: got %h want ffffffff", hilo_rdata);
        end
`else
        tick;
        drive(1'b1, F_DIV, 32'hFFFF_FFF9, 32'd2); #1;
        n_tests++;
        if (stall !== 1'b0) begin
            n_fail++; $display("FAIL div_ignored_stall: got %b want 0", stall);
        end
        tick;
        drive(1'b0, 6'd0, 32'd0, 32'd0); #1;
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL div_ignored_busy: got %b want 0", busy);
        end
`endif
        tick;
        drive(1'b0, 6'd0, 32'd0, 32'd0);
    endtask

    initial begin
        test_reset;
        test_divu(32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        test_divu(32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1);
        test_stall;
        test_back_to_back;
        test_flush;
        test_divu(32'd40, 32'd0, 32'hFFFF_FFFF, 32'd40, 1'b1);
        test_async_reset;
        test_signed;
        test_divu(32'h8000_0000, 32'h8000_0000, 32'd1, 32'd0, 1'b0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1);
    end

endmodule
`default_nettype wire
